// File: rtl/rtc_calendar.sv
// rtc_calendar
//   Divides the system clock down to a 1 Hz advance and keeps a binary
//   calendar for years 2000-2099 (year field = years since 2000). A
//   validated load port sets all six fields at once.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   run         1 = prescaler counts, 0 = time and prescaler frozen
//   load        request to load the set_* fields (evaluated every cycle)
//   set_*       candidate year/month/day/hour/minute/second
//   year..second  registered calendar fields
//   tick_1hz    one-cycle pulse aligned with each one-second advance
//   load_err    one-cycle pulse when a load request is rejected
module rtc_calendar #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       load,
  input  logic [6:0] set_year,
  input  logic [3:0] set_month,
  input  logic [4:0] set_day,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_minute,
  input  logic [5:0] set_second,
  output logic [6:0] year,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       tick_1hz,
  output logic       load_err
);

  localparam int unsigned    PW      = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRE_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] prescaler;

  // Leap rule year[1:0]==0 is exact across 2000-2099 (2000 is a leap year).
  function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                               input logic [6:0] y);
    logic [4:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      4'd2:                    d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  logic       load_ok;
  logic       advance;
  logic [4:0] dim;
  logic       c_min, c_hour, c_day, c_month, c_year;
  logic [6:0] n_year;
  logic [3:0] n_month;
  logic [4:0] n_day;
  logic [4:0] n_hour;
  logic [5:0] n_minute;
  logic [5:0] n_second;

  always_comb begin
    load_ok = (set_year   <= 7'd99) &&
              (set_month  >= 4'd1) && (set_month <= 4'd12) &&
              (set_day    >= 5'd1) &&
              (set_day    <= days_in_month(set_month, set_year)) &&
              (set_hour   <= 5'd23) &&
              (set_minute <= 6'd59) &&
              (set_second <= 6'd59);
  end

  assign advance = run && (prescaler == PRE_MAX);

  // Whole carry chain resolved in one cycle from the current fields.
  always_comb begin
    n_year   = year;
    n_month  = month;
    n_day    = day;
    n_hour   = hour;
    n_minute = minute;
    dim      = days_in_month(month, year);

    c_min    = (second == 6'd59);
    n_second = c_min ? '0 : second + 6'd1;

    c_hour = c_min && (minute == 6'd59);
    if (c_min)
      n_minute = (minute == 6'd59) ? '0 : minute + 6'd1;

    c_day = c_hour && (hour == 5'd23);
    if (c_hour)
      n_hour = (hour == 5'd23) ? '0 : hour + 5'd1;

    c_month = c_day && (day == dim);
    if (c_day)
      n_day = (day == dim) ? 5'd1 : day + 5'd1;

    c_year = c_month && (month == 4'd12);
    if (c_month)
      n_month = (month == 4'd12) ? 4'd1 : month + 4'd1;

    if (c_year)
      n_year = (year == 7'd99) ? '0 : year + 7'd1;
  end

  // An accepted load overrides any advance due on the same cycle. A
  // rejected load only raises load_err; timekeeping carries on as if the
  // request had not been made.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      year      <= '0;
      month     <= 4'd1;
      day       <= 5'd1;
      hour      <= '0;
      minute    <= '0;
      second    <= '0;
      tick_1hz  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      tick_1hz <= 1'b0;
      load_err <= 1'b0;
      if (load && load_ok) begin
        prescaler <= '0;
        year      <= set_year;
        month     <= set_month;
        day       <= set_day;
        hour      <= set_hour;
        minute    <= set_minute;
        second    <= set_second;
      end else begin
        if (load)
          load_err <= 1'b1;
        if (advance) begin
          prescaler <= '0;
          tick_1hz  <= 1'b1;
          year      <= n_year;
          month     <= n_month;
          day       <= n_day;
          hour      <= n_hour;
          minute    <= n_minute;
          second    <= n_second;
        end else if (run) begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/rtc_calendar.md
Name: rtc_calendar

Overview:
Timekeeping stage upstream of the BCD converters and LCD string formatter in the watch top level. It divides the system clock to a 1 Hz tick and maintains a full calendar: year 2000-2099, month, day, hour, minute and second. All fields are binary outputs, so they feed bin2BCD directly. A validated load port lets a future button/UI block set the time.

Parameters:
CLK_HZ, 50000000, system clock frequency; the prescaler wraps every CLK_HZ cycles (minimum 2).

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  asynchronous, active-low reset.
run  input  1  1 = prescaler counts; 0 = time frozen and prescaler held.
load  input  1  single-cycle request to load the set_* fields.
set_year  input  7  years since 2000, 0-99.
set_month  input  4  month, 1-12.
set_day  input  5  day, 1 to days-in-month.
set_hour  input  5  hour, 0-23.
set_minute  input  6  minute, 0-59.
set_second  input  6  second, 0-59.
year  output  7  years since 2000.
month  output  4  month, 1-12.
day  output  5  day, 1-31.
hour  output  5  hour, 0-23.
minute  output  6  minute, 0-59.
second  output  6  second, 0-59.
tick_1hz  output  1  one-cycle pulse on the cycle the time advances.
load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst=0, async): prescaler=0, year=0, month=1, day=1, hour=0, minute=0, second=0, tick_1hz=0, load_err=0.
- Prescaler: counts 0..CLK_HZ-1 while run=1. It holds its value while run=0.
- Advance condition: run=1 and prescaler=CLK_HZ-1. On that cycle:
  - prescaler wraps to 0.
  - tick_1hz=1 on the next cycle, registered and aligned with the new time values.
  - The time advances by one second.
- Carry chain, all in the same cycle:
  - second 59 wraps to 0 and carries to minute.
  - minute 59 wraps to 0 and carries to hour.
  - hour 23 wraps to 0 and carries to day.
  - day equal to days-in-month wraps to 1 and carries to month.
  - month 12 wraps to 1 and carries to year.
  - year 99 wraps to 0.
- Days-in-month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if year[1:0]==0, else 28. This is exact for 2000-2099.
- Load validation:
  - Checked combinationally against set_month, set_year and the rules above.
  - Valid requires every field in range, set_month nonzero and set_day nonzero.
- Load accepted (load=1, valid):
  - All six fields are registered next edge.
  - prescaler clears to 0, so the first tick occurs a full CLK_HZ cycles after the load.
  - tick_1hz is suppressed that cycle.
- Load rejected (load=1, invalid):
  - No state change.
  - load_err=1 for one cycle, registered.
- Load and tick in the same cycle: load wins. No increment, no tick_1hz, prescaler cleared.
- load while run=0: accepted normally. Time stays frozen until run returns to 1.
- load held high for multiple cycles: evaluated every cycle. Each cycle re-loads (or re-errors) and keeps the prescaler at 0.
- Outputs are registered. There is no combinational path from inputs to outputs.
- Prescaler width: clog2(CLK_HZ) bits.

Test Plan:
1. Reset then count, CLK_HZ=4, run=1 -> time 00-01-01 00:00:00 after reset; tick_1hz every 4 cycles; second=1 after the first tick; second=3 after 12 cycles.
2. Full cascade, load 99-12-31 23:59:59 -> after one tick: year=0, month=1, day=1, hour=0, minute=0, second=0.
3. Leap rules:
   - Load 24-02-28 23:59:59, tick -> day=29, month=2.
   - Load 23-02-28 23:59:59, tick -> day=1, month=3.
   - Load 24-02-29 23:59:59, tick -> 03-01.
4. Invalid loads, each -> load_err pulses once and the time is unchanged:
   - day 31 in month 4
   - day 29 in month 2 with year=23
   - month 0
   - month 13
   - hour 24
   - second 60
5. Load colliding with tick: load pulsed on the cycle prescaler=3 (CLK_HZ=4) -> loaded values appear, no tick_1hz, next tick 4 cycles later.
6. run and reset control:
   - run=0 for 10 cycles mid-count -> second and prescaler frozen; counting resumes from the held prescaler value.
   - rst asserted mid-second -> immediate return to reset values without waiting for a clock edge.
